// File: rtl/mem_arb.sv
// Two-requester memory port arbiter: load/store (D) over fetch (I) with a
// starvation limit, one outstanding transaction, responses routed to the owner.
module mem_arb #(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_i_valid,
  output logic          o_i_ready,
  input  logic [AW-1:0] i_i_addr,
  output logic          o_i_rvalid,
  output logic [DW-1:0] o_i_rdata,
  input  logic          i_d_valid,
  output logic          o_d_ready,
  input  logic [AW-1:0] i_d_addr,
  input  logic          i_d_wen,
  input  logic [DW-1:0] i_d_wdata,
  input  logic [7:0]    i_d_wmask,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_mem_valid,
  input  logic          i_mem_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
  output logic [7:0]    o_mem_wmask,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;   // 1 = D owns the transaction
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic          grant_d, grant_i;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // D loses only when I is also waiting and D has used up its streak.
  assign grant_d = i_d_valid && (!i_i_valid || (cnt_q < LIM));
  assign grant_i = i_i_valid && !grant_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    o_i_ready   = 1'b0;
    o_d_ready   = 1'b0;
    o_i_rvalid  = 1'b0;
    o_i_rdata   = '0;
    o_d_rvalid  = 1'b0;
    o_d_rdata   = '0;
    o_mem_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    unique case (state_q)
      IDLE: begin
        o_d_ready = grant_d;
        o_i_ready = grant_i;
        if (grant_d) begin
          owner_d = 1'b1;
          addr_d  = i_d_addr;
          wen_d   = i_d_wen;
          wdata_d = i_d_wdata;
          wmask_d = i_d_wen ? i_d_wmask : 8'h00;
          cnt_d   = i_i_valid ? ((cnt_q >= LIM) ? LIM : cnt_q + 4'd1) : 4'd0;
          state_d = ISSUE;
        end else if (grant_i) begin
          owner_d = 1'b0;
          addr_d  = i_i_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = addr_q;
        o_mem_wen   = wen_q;
        o_mem_wdata = wdata_q;
        o_mem_wmask = wmask_q;
        if (i_mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          if (owner_q) begin
            o_d_rvalid = 1'b1;
            o_d_rdata  = i_mem_rdata;
          end else begin
            o_i_rvalid = 1'b1;
            o_i_rdata  = i_mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: expected memory requests and responses are
// queued when a requester is driven and retired as the DUT produces them.
module tb_mem_arb;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_ready, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_valid, d_ready, d_rvalid, d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [7:0]    d_wmask;
  logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_wmask;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_i_valid(i_valid), .o_i_ready(i_ready), .i_i_addr(i_addr),
    .o_i_rvalid(i_rvalid), .o_i_rdata(i_rdata),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_addr(d_addr),
    .i_d_wen(d_wen), .i_d_wdata(d_wdata), .i_d_wmask(d_wmask),
    .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [7:0]    wmask;
  } req_t;

  typedef struct {
    logic          port;   // 1 = D
    logic [DW-1:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int resp_cyc = 0;
  int memv_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // Memory model: ready after ready_wait cycles of valid, response mem_lat
  // cycles after acceptance, data = mem_knob ^ address. spur forces a stray rvalid.
  int            ready_wait = 0, mem_lat = 0, m_rdy = 0, m_cnt = 0;
  bit            m_pend = 0, hs = 0, spur = 0;
  logic [AW-1:0] m_addr = '0, hs_addr = '0;
  logic [DW-1:0] mem_knob = '0;

  always @(posedge clk) begin
    #1;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (!rst_n) begin
      m_pend = 0; hs = 0; m_cnt = 0; m_rdy = ready_wait;
    end else begin
      if (hs) begin
        m_pend = 1; m_cnt = mem_lat; m_addr = hs_addr;
      end
      hs = 0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_knob ^ m_addr;
          m_pend     = 0;
        end else m_cnt--;
      end else begin
        if (spur) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 64'hbad0_bad0_bad0_bad0;
        end
        if (mem_valid) begin
          if (m_rdy == 0) begin
            mem_ready = 1'b1; hs = 1; hs_addr = mem_addr; m_rdy = ready_wait;
          end else m_rdy--;
        end
      end
    end
  end

  // Monitor: sample mid-cycle, compare against the scoreboard heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!i_rvalid) check("i_rdata_idle", i_rdata, '0);
      if (!d_rvalid) check("d_rdata_idle", d_rdata, '0);
      if (i_rvalid || d_rvalid) begin
        resp_cyc = cyc;
        if (resp_q.size() == 0) check("unexpected_rvalid", {62'd0, d_rvalid, i_rvalid}, '0);
        else begin
          resp_t e;
          e = resp_q.pop_front();
          check("rvalid_port", {62'd0, d_rvalid, i_rvalid}, e.port ? 64'd2 : 64'd1);
          check("rdata", e.port ? d_rdata : i_rdata, e.data);
        end
      end
      if (mem_valid) begin
        memv_cnt++;
        if (req_q.size() == 0) check("unexpected_mem_valid", 1, 0);
        else begin
          req_t r;
          r = req_q[0];
          check("mem_addr", mem_addr, r.addr);
          check("mem_wen", {63'd0, mem_wen}, {63'd0, r.wen});
          check("mem_wmask", {56'd0, mem_wmask}, {56'd0, r.wmask});
          if (r.wen) check("mem_wdata", mem_wdata, r.wdata);
          if (mem_ready) void'(req_q.pop_front());
        end
      end
    end
  end

  task automatic set_mem(input int rw, input int lat);
    ready_wait = rw; m_rdy = rw; mem_lat = lat;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((req_q.size() != 0 || resp_q.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check("timeout", 1, 0);
    @(posedge clk); #2;
  endtask

  // Drives one request, returns the cycle in which it was granted.
  task automatic do_req(input bit port, input logic [AW-1:0] addr, input bit wen,
                        input logic [DW-1:0] wdata, input logic [7:0] wmask,
                        input logic [DW-1:0] exp_data, output int gcyc);
    req_t  r;
    resp_t e;
    int    n;
    r.addr = addr; r.wen = port & wen; r.wdata = wdata;
    r.wmask = (port & wen) ? wmask : 8'h00;
    e.port = port; e.data = exp_data;
    req_q.push_back(r);
    resp_q.push_back(e);
    @(posedge clk); #2;
    if (port) begin
      d_valid = 1; d_addr = addr; d_wen = wen; d_wdata = wdata; d_wmask = wmask;
    end else begin
      i_valid = 1; i_addr = addr;
    end
    n = 0; gcyc = 0;
    forever begin
      @(negedge clk);
      if ((port ? d_ready : i_ready) == 1'b1) begin gcyc = cyc; break; end
      if (++n > 50) begin check("grant_timeout", 1, 0); break; end
    end
    @(posedge clk); #2;
    d_valid = 0; i_valid = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_mem_valid"}, {63'd0, mem_valid}, '0);
    check({tag, "_readies"}, {62'd0, d_ready, i_ready}, '0);
    check({tag, "_rvalids"}, {62'd0, d_rvalid, i_rvalid}, '0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wmask"}, {56'd0, mem_wmask}, '0);
  endtask

  initial begin
    int g;
    int grants;
    int n;
    resp_t e;
    req_t  r;
    rst_n = 0;
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2 chk_outputs_zero("reset");
    @(negedge clk) rst_n = 1;

    // Single load: grant -> response two cycles later
    set_mem(0, 0);
    mem_knob = 64'h1122334455667788 ^ 64'h80000010;
    do_req(1, 64'h80000010, 0, '0, 8'h00, 64'h1122334455667788, g);
    wait_done();
    check("load_latency", resp_cyc - g, 2);

    // Store held off by three cycles of backpressure
    set_mem(3, 0);
    mem_knob = '0;
    memv_cnt = 0;
    do_req(1, 64'h80000040, 1, 64'hdeadbeef, 8'h0f, 64'h80000040, g);
    wait_done();
    check("store_valid_cycles", memv_cnt, 4);

    // Fetch only
    set_mem(0, 2);
    do_req(0, 64'h80000000, 0, '0, 8'h00, 64'h80000000, g);
    wait_done();
    check("fetch_latency", resp_cyc - g, 4);

    // Priority with both requesters continuously valid
    set_mem(0, 0);
    for (int unsigned k = 0; k < 10; k++) begin
      r.wen = 0; r.wdata = '0; r.wmask = '0;
      e.port = (k % 5) != 4;
      r.addr = e.port ? 64'h100 : 64'h200;
      e.data = r.addr;
      req_q.push_back(r);
      resp_q.push_back(e);
    end
    @(posedge clk); #2;
    d_valid = 1; d_addr = 64'h100; d_wen = 0; d_wmask = '0;
    i_valid = 1; i_addr = 64'h200;
    grants = 0; n = 0;
    while (grants < 10 && n < 300) begin
      @(negedge clk); n++;
      if (d_ready || i_ready) grants++;
    end
    check("priority_grants", grants, 10);
    @(posedge clk); #2;
    d_valid = 0; i_valid = 0;
    wait_done();

    // Spurious responses in IDLE, then in ISSUE under backpressure
    spur = 1;
    repeat (3) @(posedge clk);
    #2 check("spur_idle_mem_valid", {63'd0, mem_valid}, '0);
    set_mem(2, 1);
    do_req(1, 64'h80000080, 0, '0, 8'h00, 64'h80000080, g);
    wait_done();
    spur = 0;
    check("spur_latency", resp_cyc - g, 5);

    // Reset while the DUT waits for a response
    set_mem(0, 20);
    do_req(1, 64'h80000100, 0, '0, 8'h00, 64'h80000100, g);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    req_q.delete();
    resp_q.delete();
    #1 chk_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    spur = 1;
    repeat (2) @(posedge clk);
    #2 chk_outputs_zero("post_reset");
    spur = 0;
    set_mem(0, 0);
    do_req(0, 64'h80000200, 0, '0, 8'h00, 64'h80000200, g);
    wait_done();
    check("post_reset_latency", resp_cyc - g, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
